// File: rtl/cpu_ctrl_fsm_if.sv
// cpu_ctrl_fsm_if: memory-side handshake bundle between the control sequencer and the datapath/memories.
//   opcode     : instr[6:0] from the IR, valid from DECODE onward
//   imem_req   : instruction fetch request
//   imem_ready : instruction memory returns data this cycle
//   ir_we      : IR latch enable
//   dmem_req   : data access request
//   dmem_we    : data access is a store
//   dmem_ready : data access completes this cycle
// master = sequencer side, slave = memory/datapath side.
interface cpu_ctrl_fsm_if;
    logic [6:0] opcode;
    logic       imem_req;
    logic       imem_ready;
    logic       ir_we;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ready;

    modport master (
        input  opcode, imem_ready, dmem_ready,
        output imem_req, ir_we, dmem_req, dmem_we
    );

    modport slave (
        output opcode, imem_ready, dmem_ready,
        input  imem_req, ir_we, dmem_req, dmem_we
    );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multicycle control sequencer for the rv32 core, one instruction in flight.
//   clk         : core clock
//   rst_n       : asynchronous active-low reset
//   bus         : fetch/IR/data-memory handshake (cpu_ctrl_fsm_if.master)
//   halt_req    : halt request, sampled only when an instruction retires
//   cpu_state   : state code (FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 6, HALT 7); PC loads in EXEC
//   rf_we       : register-file write enable (WB)
//   instret     : one-cycle retire pulse
//   busy        : low only in HALT (and before the first edge after reset)
//   mem_timeout : sticky flag, set when a FETCH/MEM wait exceeds MEM_WAIT_MAX cycles
// Parameter MEM_WAIT_MAX: 0 = unbounded wait, N > 0 = abort to FETCH after N wait cycles.
// Macro CPU_ILLEGAL_TRAP_EN: illegal opcodes go to TRAP (left only by reset) instead of retiring as NOP.
module cpu_ctrl_fsm #(
    parameter int unsigned MEM_WAIT_MAX = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cpu_ctrl_fsm_if.master       bus,
    input  logic                 halt_req,
    output logic [2:0]           cpu_state,
    output logic                 rf_we,
    output logic                 instret,
    output logic                 busy,
    output logic                 mem_timeout
);

    localparam int CW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] WAIT_LIM = CW'(MEM_WAIT_MAX);

`ifdef CPU_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd6,
        HALT   = 3'd7
    } state_t;

    state_t        state, state_d;
    logic          started;
    logic [CW-1:0] wait_cnt, wait_cnt_d;
    logic          is_load, is_store, is_wb, is_ret;
    logic          waiting, abort, retire;

    assign is_load  = bus.opcode == 7'b0000011;
    assign is_store = bus.opcode == 7'b0100011;
    assign is_wb    = bus.opcode inside {7'b0110111, 7'b0010111, 7'b1101111,
                                         7'b1100111, 7'b0010011, 7'b0110011};
    assign is_ret   = bus.opcode inside {7'b1100011, 7'b0001111, 7'b1110011};

    // A wait cycle is one where the memory being waited on has not answered yet.
    assign waiting = started && ((state == FETCH && !bus.imem_ready) ||
                                 (state == MEM && !bus.dmem_ready));
    // Ready in the limit cycle is not a wait cycle, so ready wins over the abort.
    assign abort   = (MEM_WAIT_MAX != 0) && waiting && wait_cnt == WAIT_LIM;

    assign cpu_state = state;
    assign instret   = retire;
    assign busy      = started && state != HALT;

    always_comb begin
        state_d      = state;
        bus.imem_req = 1'b0;
        bus.ir_we    = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        rf_we        = 1'b0;
        retire       = 1'b0;
        if (started) begin
            case (state)
                FETCH: begin
                    bus.imem_req = 1'b1;
                    if (bus.imem_ready) begin
                        bus.ir_we = 1'b1;
                        state_d   = DECODE;
                    end
                end
                DECODE: state_d = EXEC;
                EXEC: begin
                    if (is_load || is_store)
                        state_d = MEM;
                    else if (is_wb)
                        state_d = WB;
                    else if (is_ret || !TRAP_EN)
                        retire = 1'b1;
                    else
                        state_d = TRAP;
                end
                MEM: begin
                    bus.dmem_req = 1'b1;
                    bus.dmem_we  = is_store;
                    if (bus.dmem_ready) begin
                        if (is_store)
                            retire = 1'b1;
                        else
                            state_d = WB;
                    end
                end
                WB: begin
                    rf_we  = 1'b1;
                    retire = 1'b1;
                end
                TRAP:    state_d = TRAP;
                HALT:    state_d = halt_req ? HALT : FETCH;
                default: state_d = FETCH;
            endcase
            if (retire)
                state_d = halt_req ? HALT : FETCH;
            if (abort)
                state_d = FETCH;
        end
    end

    // Counter restarts on every state change and on an abort (FETCH re-entry).
    always_comb begin
        wait_cnt_d = wait_cnt;
        if (abort || state_d != state)
            wait_cnt_d = '0;
        else if (waiting && MEM_WAIT_MAX != 0)
            wait_cnt_d = wait_cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            started     <= 1'b0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_d;
            started  <= 1'b1;
            wait_cnt <= wait_cnt_d;
            if (abort)
                mem_timeout <= 1'b1;
        end
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
Multicycle control sequencer for the rv32 core. It generates the `cpu_state` code that gates the PC register, which loads only in EXEC (`cpu_state` = 3'd2). It also drives the instruction-fetch handshake, the IR latch, the data-memory handshake and register-file writeback. It sits between the memories and the datapath, with one instruction in flight at a time.

Parameters:
- `MEM_WAIT_MAX`, default 0: 0 means unbounded memory wait. N>0 means a MEM or FETCH wait longer than N cycles raises `mem_timeout`, and the FSM aborts to FETCH.

Ports:
- `clk` input 1: core clock.
- `rst_n` input 1: asynchronous active-low reset.
- `opcode` input 7: `instr[6:0]` from the IR; valid from DECODE onward.
- `imem_ready` input 1: instruction memory has returned data this cycle.
- `dmem_ready` input 1: data access completes this cycle.
- `halt_req` input 1: debug/testbench halt request.
- `cpu_state` output 3: current state code.
- `imem_req` output 1: fetch request.
- `ir_we` output 1: IR latch enable.
- `dmem_req` output 1: data access request.
- `dmem_we` output 1: 1 = store.
- `rf_we` output 1: register-file write enable.
- `instret` output 1: one-cycle retire pulse.
- `busy` output 1: 0 only in HALT.
- `mem_timeout` output 1: sticky timeout flag.

Behaviour:
- One clock domain: `clk`. Reset `rst_n` is asynchronous, active-low.
- State codes:
  - FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 6, HALT = 7.
  - Code 5 is unused; if ever reached, go to FETCH next cycle.
- Reset values:
  - `cpu_state` = 0.
  - Internal `started` flop = 0; it sets on the first clock edge after reset release.
  - `mem_timeout` = 0.
  - All other outputs decode to 0 while `started` = 0.
- `imem_req` = FETCH && `started`. Hold it until `imem_ready`.
- FETCH exit: in the `imem_ready` cycle, `ir_we` = 1 and next state = DECODE.
- DECODE: always 1 cycle, then EXEC.
- EXEC: 1 cycle; the PC updates on this exit edge. Next state depends on `opcode`:
  - 0000011 (load) or 0100011 (store): MEM.
  - 0110111, 0010111, 1101111, 1100111, 0010011, 0110011: WB.
  - 1100011, 0001111, 1110011: retire.
  - Any other opcode: handled per Optional Feature.
- MEM:
  - `dmem_req` = 1; `dmem_we` = 1 for store only.
  - Hold until `dmem_ready`.
  - Load then goes to WB; store retires.
- WB: `rf_we` = 1 for exactly 1 cycle, then retire.
- Retire means:
  - `instret` = 1 in that final cycle (EXEC, MEM's ready cycle, or WB).
  - Next state = HALT if `halt_req` = 1, else FETCH.
- `halt_req` is sampled only at retire; an instruction in flight always completes.
- HALT: `busy` = 0 and no requests. Exit to FETCH in the first cycle `halt_req` = 0.
- Latency with zero-wait memories:
  - ALU/JAL: 4 cycles.
  - Branch/FENCE/SYSTEM: 3 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
- Timeout (`MEM_WAIT_MAX` > 0):
  - A wait counter (`$clog2(MEM_WAIT_MAX+1)` bits) clears on entry to FETCH or MEM and increments each cycle the ready input is low.
  - When the counter reaches `MEM_WAIT_MAX` with ready still low, `mem_timeout` sets (sticky) and next state = FETCH.
  - No `instret`, `rf_we` or `ir_we` is issued for the aborted instruction.
- Simultaneous ready and counter limit: ready wins, and the instruction completes normally.
- Reset asserted mid-operation: immediate return to FETCH, all outputs 0, and `started` is cleared.

Optional Feature:
- Macro: `CPU_ILLEGAL_TRAP_EN`.
- Defined:
  - An opcode outside the legal set in EXEC goes to TRAP (code 6).
  - TRAP asserts no requests, no `instret`, and `busy` = 1.
  - TRAP is exited only by reset.
  - The PC has still updated (+4) on the EXEC edge.
- Not defined:
  - An illegal opcode is retired as a NOP from EXEC, with `instret` = 1.
  - TRAP is unreachable.

Test Plan:
1. Release reset, `imem_ready` = 1 constantly, `opcode` = 0110011:
   - `cpu_state` sequence 0,0,1,2,4,0 (one idle FETCH from `started`).
   - `ir_we` is high in cycle 2, `rf_we` in cycle 5, `instret` in cycle 5.
2. `opcode` = 0000011, `dmem_ready` low 3 cycles:
   - MEM lasts 4 cycles with `dmem_req` = 1 and `dmem_we` = 0, then WB with `rf_we` = 1.
   - `instret` once.
3. `opcode` = 0100011, `dmem_ready` = 1:
   - States 0,1,2,3,0.
   - `dmem_we` = 1 for one cycle and `instret` in the MEM cycle; `rf_we` never asserted.
4. `opcode` = 1100011 with `halt_req` raised during DECODE:
   - EXEC retires, then state 7 with `busy` = 0.
   - Drop `halt_req` and the state returns to 0 next cycle.
5. `MEM_WAIT_MAX` = 4, `imem_ready` held 0:
   - `mem_timeout` sets after 4 FETCH cycles; FETCH re-enters with the counter cleared.
   - Pulse `rst_n` low mid-DECODE: `cpu_state` = 0 immediately and `mem_timeout` = 0.
6. `opcode` = 1111111:
   - With `CPU_ILLEGAL_TRAP_EN`, the state is stuck at 6 and `instret` = 0.
   - Without it, states 0,1,2,0 and `instret` = 1.
